// File: rtl/pcie_rx_comma_align.sv
// Receive-side 8b/10b symbol aligner: searches a 20-bit window of two received
// words for a comma, latches its bit offset, and holds symbol lock with hysteresis.
module pcie_rx_comma_align #(
   parameter int LOCK_COMMAS = 3,
   parameter int UNLOCK_ERRS = 4,
   parameter int TIMEOUT     = 1024
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] rx_word,
   input  logic       rx_elecidle,
   output logic [9:0] sym_out,
   output logic       sym_valid,
   output logic       sym_is_comma,
   output logic       locked,
   output logic [3:0] align_offset,
   output logic       relock_pulse
);
   localparam int CW = $clog2(LOCK_COMMAS) + 1;
   localparam int EW = $clog2(UNLOCK_ERRS) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [EW-1:0] ERR_MAX = '1;
   localparam logic [TW-1:0] TMO_MAX = '1;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_CHECK    = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   function automatic logic is_comma(input logic [9:0] s);
      return (s[9:3] == 7'b0011111) || (s[9:3] == 7'b1100000);
   endfunction

   logic [9:0]    r1_reg;
   logic [9:0]    r2_reg;
   logic          idle1_reg;
   logic          idle2_reg;
   logic [19:1]   window;
   logic          win_idle;
   logic [9:0]    cand [10];
   logic [9:0]    hit;
   logic          any_hit;
   logic          hit_at_offset;
   logic [3:0]    first_hit;
   logic [9:0]    cand_sel;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_inc;
   logic [EW-1:0] err_reg;
   logic [EW-1:0] err_inc;
   logic [TW-1:0] tmo_reg;
   logic [TW-1:0] tmo_inc;

   // The oldest bit sits at the top; offset 9 reaches down to r1 bit 1,
   // so r1 bit 0 only ever matters once it has moved into r2.
   assign window   = {r2_reg, r1_reg[9:1]};
   assign win_idle = idle1_reg | idle2_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 10; gi++) begin : g_cand
         assign cand[gi] = window[19-gi -: 10];
         assign hit[gi]  = ~win_idle & is_comma(cand[gi]);
      end
   endgenerate

   // Lowest offset wins when several positions look like a comma.
   always_comb begin
      first_hit = 4'd0;
      for (int i = 9; i >= 0; i--) begin
         if (hit[i]) first_hit = 4'(i);
      end
   end

   assign any_hit       = |hit;
   assign hit_at_offset = hit[align_offset];
   assign cand_sel      = cand[align_offset];

   assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
   assign err_inc = (err_reg == ERR_MAX) ? err_reg : err_reg + EW'(1);
   assign tmo_inc = (tmo_reg == TMO_MAX) ? tmo_reg : tmo_reg + TW'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r1_reg       <= '0;
         r2_reg       <= '0;
         idle1_reg    <= 1'b0;
         idle2_reg    <= 1'b0;
         sym_out      <= '0;
         sym_is_comma <= 1'b0;
      end else begin
         r1_reg       <= rx_word;
         r2_reg       <= r1_reg;
         idle1_reg    <= rx_elecidle;
         idle2_reg    <= idle1_reg;
         sym_out      <= cand_sel;
         sym_is_comma <= is_comma(cand_sel);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_UNLOCKED;
         cnt_reg      <= '0;
         err_reg      <= '0;
         tmo_reg      <= '0;
         align_offset <= 4'd0;
         locked       <= 1'b0;
         sym_valid    <= 1'b0;
         relock_pulse <= 1'b0;
      end else begin
         relock_pulse <= 1'b0;
         locked       <= 1'b0;
         sym_valid    <= 1'b0;
         if (rx_elecidle) begin
            state_reg <= ST_UNLOCKED;
         end else begin
            case (state_reg)
               ST_UNLOCKED: begin
                  if (any_hit) begin
                     align_offset <= first_hit;
                     cnt_reg      <= CW'(1);
                     tmo_reg      <= '0;
                     state_reg    <= ST_CHECK;
                  end
               end
               ST_CHECK: begin
                  // A confirming comma outranks stray hits elsewhere in the window.
                  if (hit_at_offset) begin
                     cnt_reg <= cnt_inc;
                     tmo_reg <= '0;
                     if (cnt_inc >= CW'(LOCK_COMMAS)) begin
                        state_reg    <= ST_LOCKED;
                        err_reg      <= '0;
                        relock_pulse <= 1'b1;
                        locked       <= 1'b1;
                        sym_valid    <= ~win_idle;
                     end
                  end else if (any_hit) begin
                     state_reg <= ST_UNLOCKED;
                  end else if (tmo_reg >= TW'(TIMEOUT - 1)) begin
                     state_reg <= ST_UNLOCKED;
                  end else begin
                     tmo_reg <= tmo_inc;
                  end
               end
               ST_LOCKED: begin
                  if (!hit_at_offset && any_hit && (err_inc >= EW'(UNLOCK_ERRS))) begin
                     err_reg   <= err_inc;
                     state_reg <= ST_UNLOCKED;
                  end else begin
                     locked    <= 1'b1;
                     sym_valid <= ~win_idle;
                     if (hit_at_offset) begin
                        err_reg <= '0;
                     end else if (any_hit) begin
                        err_reg <= err_inc;
                     end
                  end
               end
               default: begin
                  state_reg <= ST_UNLOCKED;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pcie_rx_comma_align.sv
// Bench for pcie_rx_comma_align: bit-serial stream generator with controllable
// rotation, a bit-level reference model, and a per-cycle output comparison.
module tb_pcie_rx_comma_align;
   localparam int LOCK_COMMAS = 3;
   localparam int UNLOCK_ERRS = 4;
   localparam int TIMEOUT     = 1024;
   localparam logic [9:0] K285 = 10'b0011111010;
   localparam logic [9:0] D215 = 10'b1010101010;
   localparam int M_UNL = 0;
   localparam int M_CHK = 1;
   localparam int M_LCK = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [9:0] rx_word = '0;
   logic       rx_elecidle = 1'b0;
   logic [9:0] sym_out;
   logic       sym_valid;
   logic       sym_is_comma;
   logic       locked;
   logic [3:0] align_offset;
   logic       relock_pulse;

   pcie_rx_comma_align #(
      .LOCK_COMMAS(LOCK_COMMAS),
      .UNLOCK_ERRS(UNLOCK_ERRS),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .rx_word(rx_word),
      .rx_elecidle(rx_elecidle),
      .sym_out(sym_out),
      .sym_valid(sym_valid),
      .sym_is_comma(sym_is_comma),
      .locked(locked),
      .align_offset(align_offset),
      .relock_pulse(relock_pulse)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   // Reference model: raw bits of the last two words, oldest bit first.
   logic [9:0] m_r1, m_r2;
   bit         m_i1, m_i2;
   int         m_mode, m_cnt, m_err, m_tmo, m_off;
   logic [9:0] exp_sym;
   bit         exp_comma, exp_valid, exp_locked, exp_pulse;
   int         exp_off;
   bit         chk_en = 1'b0;

   function automatic bit m_is_comma(input logic [9:0] s);
      return (s[9:3] == 7'b0011111) || (s[9:3] == 7'b1100000);
   endfunction

   function automatic logic [9:0] m_cand(input int k);
      bit b[20];
      logic [9:0] v;
      for (int i = 0; i < 10; i++) begin
         b[i]      = m_r2[9-i];
         b[10 + i] = m_r1[9-i];
      end
      v = '0;
      for (int j = 0; j < 10; j++) v = {v[8:0], b[k+j]};
      return v;
   endfunction

   task automatic model_reset();
      m_r1 = '0; m_r2 = '0; m_i1 = 0; m_i2 = 0;
      m_mode = M_UNL; m_cnt = 0; m_err = 0; m_tmo = 0; m_off = 0;
      exp_sym = '0; exp_comma = 0; exp_valid = 0; exp_locked = 0; exp_pulse = 0; exp_off = 0;
   endtask

   task automatic model_step(input logic [9:0] w, input bit idle);
      bit masked;
      bit at_off;
      int first;
      logic [9:0] out_sym;
      if (reset) begin
         model_reset();
         return;
      end
      masked = m_i1 || m_i2;
      first = -1;
      for (int k = 9; k >= 0; k--) if (!masked && m_is_comma(m_cand(k))) first = k;
      at_off  = !masked && m_is_comma(m_cand(m_off));
      out_sym = m_cand(m_off);
      exp_pulse = 0;
      if (idle) begin
         m_mode = M_UNL;
      end else if (m_mode == M_UNL) begin
         if (first >= 0) begin
            m_off = first; m_cnt = 1; m_tmo = 0; m_mode = M_CHK;
         end
      end else if (m_mode == M_CHK) begin
         if (at_off) begin
            m_tmo = 0;
            m_cnt++;
            if (m_cnt >= LOCK_COMMAS) begin
               m_mode = M_LCK; m_err = 0; exp_pulse = 1;
            end
         end else if (first >= 0) m_mode = M_UNL;
         else if (m_tmo == TIMEOUT - 1) m_mode = M_UNL;
         else m_tmo++;
      end else begin
         if (at_off) m_err = 0;
         else if (first >= 0) begin
            m_err++;
            if (m_err >= UNLOCK_ERRS) m_mode = M_UNL;
         end
      end
      exp_sym    = out_sym;
      exp_comma  = m_is_comma(out_sym);
      exp_off    = m_off;
      exp_locked = (m_mode == M_LCK);
      exp_valid  = exp_locked && !masked;
      m_r2 = m_r1; m_r1 = w; m_i2 = m_i1; m_i1 = idle;
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         check("sym_out", {22'd0, sym_out}, {22'd0, exp_sym});
         check("sym_valid", {31'd0, sym_valid}, {31'd0, exp_valid});
         check("sym_is_comma", {31'd0, sym_is_comma}, {31'd0, exp_comma});
         check("locked", {31'd0, locked}, {31'd0, exp_locked});
         check("align_offset", {28'd0, align_offset}, exp_off);
         check("relock_pulse", {31'd0, relock_pulse}, {31'd0, exp_pulse});
      end
   end

   // Stimulus plumbing and event bookkeeping
   int  ncyc = 0, rise_cnt = 0, fall_cnt = 0, pulse_cnt = 0, rise_cyc = 0, sc_cnt = 0;
   int  comma_cnt = 0, comma_at_rise = -1, comma_at_fall = -1;
   bit  prev_locked = 0;
   bit  rand_idle = 0;
   bit  bq[$];

   task automatic drive(input logic [9:0] w, input bit idle);
      rx_word = w;
      rx_elecidle = idle;
      @(posedge clock);
      #1;
      model_step(w, idle);
      ncyc++;
      if (locked === 1'b1 && !prev_locked) begin
         rise_cnt++; rise_cyc = ncyc; comma_at_rise = comma_cnt;
      end
      if (locked !== 1'b1 && prev_locked) begin
         fall_cnt++; comma_at_fall = comma_cnt;
      end
      prev_locked = (locked === 1'b1);
      if (relock_pulse === 1'b1) pulse_cnt++;
      if (sym_is_comma === 1'b1) sc_cnt++;
   endtask

   task automatic flush_words();
      logic [9:0] w;
      while (bq.size() >= 10) begin
         w = '0;
         for (int j = 0; j < 10; j++) w = {w[8:0], bq.pop_front()};
         if (rand_idle && $urandom_range(0, 59) == 0) drive(10'($urandom), 1'b1);
         drive(w, 1'b0);
      end
   endtask

   task automatic push_sym(input logic [9:0] v);
      for (int j = 9; j >= 0; j--) bq.push_back(v[j]);
      flush_words();
   endtask

   task automatic push_bits(input int n);
      for (int j = 0; j < n; j++) bq.push_back(j % 2 == 0);
      flush_words();
   endtask

   task automatic period(input int nfill, input bit rnd);
      comma_cnt++;
      push_sym(K285);
      repeat (nfill) push_sym(rnd ? 10'($urandom_range(0, 1023)) : D215);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, p0, sc0, r0;
      #1;
      reset = 1'b1;
      model_reset();
      chk_en = 1'b1;
      repeat (3) drive(D215, 1'b0);
      check("reset_sym_out", {22'd0, sym_out}, 32'd0);
      check("reset_locked", {31'd0, locked}, 32'd0);
      reset = 1'b0;

      // Aligned stream, commas every 16 words at offset 0
      bq.delete();
      base = ncyc; p0 = pulse_cnt; sc0 = sc_cnt; comma_cnt = 0; comma_at_rise = -1;
      repeat (4) period(15, 1'b0);
      check("A_lock_latency", rise_cyc - base, 35);
      check("A_offset", {28'd0, align_offset}, 32'd0);
      check("A_pulses", pulse_cnt - p0, 1);
      check("A_comma_flags", sc_cnt - sc0, 4);

      // Slip the stream by 7 bits while locked
      p0 = pulse_cnt; comma_cnt = 0; comma_at_rise = -1; comma_at_fall = -1;
      push_bits(7);
      repeat (8) period(15, 1'b0);
      check("C_drop_on_comma", comma_at_fall, 4);
      check("C_relock_on_comma", comma_at_rise, 7);
      check("C_offset", {28'd0, align_offset}, 32'd7);
      check("C_pulses", pulse_cnt - p0, 1);

      // One idle word while locked
      period(8, 1'b0);
      drive(10'($urandom), 1'b1);
      check("D_locked_after_idle", {31'd0, locked}, 32'd0);
      check("D_valid_after_idle", {31'd0, sym_valid}, 32'd0);
      comma_cnt = 0; comma_at_rise = -1;
      repeat (7) push_sym(D215);
      repeat (4) period(15, 1'b0);
      check("D_relock_on_comma", comma_at_rise, 3);
      check("D_locked", {31'd0, locked}, 32'd1);

      // Two commas, then a long silence that must expire CHECK
      drive(10'd0, 1'b1);
      comma_cnt = 0; comma_at_rise = -1; r0 = rise_cnt;
      repeat (2) period(15, 1'b0);
      repeat (1100) push_sym(D215);
      period(15, 1'b0);
      check("E_no_lock_after_timeout", rise_cnt - r0, 0);
      repeat (3) period(15, 1'b0);
      check("E_relock_on_comma", comma_at_rise, 5);

      // Asynchronous reset in the middle of a locked stream
      #3;
      reset = 1'b1;
      model_reset();
      #2;
      check("F_sym_out_async", {22'd0, sym_out}, 32'd0);
      check("F_locked_async", {31'd0, locked}, 32'd0);
      check("F_valid_async", {31'd0, sym_valid}, 32'd0);
      check("F_offset_async", {28'd0, align_offset}, 32'd0);
      repeat (2) drive(D215, 1'b0);
      reset = 1'b0;
      bq.delete();
      comma_cnt = 0; comma_at_rise = -1;
      push_bits(5);
      repeat (4) period(15, 1'b0);
      check("F_relock_on_comma", comma_at_rise, 3);
      check("F_offset", {28'd0, align_offset}, 32'd5);

      // Random data, random rotations, bit slips and idle bursts
      rand_idle = 1'b1;
      repeat (6) begin
         drive(10'($urandom), 1'b1);
         bq.delete();
         push_bits($urandom_range(0, 9));
         repeat (12) begin
            period($urandom_range(6, 20), 1'b1);
            if ($urandom_range(0, 7) == 0) push_bits($urandom_range(1, 9));
         end
      end
      rand_idle = 1'b0;
      repeat (5) push_sym(D215);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
